// File: rtl/sr_cmd_debounce.sv
// Set/reset push-button front end: per-channel sync + debounce + rise detect,
// then a registered command stage that never lets s and r fire together.

module sr_cmd_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);
  logic             meta, sync, db_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= btn;
      sync <= meta;
      db_d <= db;
      // any agreeing sample restarts the count, so short glitches never land
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = db & ~db_d;
endmodule

module sr_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic set_level,
  output logic rst_level
);
  localparam int NUM_CH = 2;  // [0] = set, [1] = reset

  logic [NUM_CH-1:0] btn, db, rise;

  assign btn = {rst_btn, set_btn};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sr_cmd_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .db   (db[i]),
      .rise (rise[i])
    );
  end

  // a rise is dropped whenever the opposite channel is currently held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= rise[0] & ~db[1];
      r        <= rise[1] & ~db[0];
      conflict <= (rise[0] & db[1]) | (rise[1] & db[0]);
    end
  end

  assign set_level = db[0];
  assign rst_level = db[1];
endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Scoreboard bench: each press queues the expected command and its cycle;
// a negedge monitor pops and compares whenever s, r or conflict fires.

module tb_sr_cmd_debounce;
  localparam int DC  = 4;
  localparam int LAT = 3 + DC;  // drive at cycle N -> pulse seen at cycle N+LAT

  logic clk = 1'b0, rst_n = 1'b0;
  logic set_btn = 1'b1, rst_btn = 1'b1;
  logic s, r, conflict, set_level, rst_level;
  logic q = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  typedef struct {
    logic [2:0] kind;  // {conflict, r, s}
    int         cyc;
  } exp_t;
  exp_t sb[$];

  localparam logic [2:0] K_S = 3'b001, K_R = 3'b010, K_C = 3'b100;

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .rst_btn  (rst_btn),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .set_level(set_level),
    .rst_level(rst_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream SR flip-flop
  always @(posedge clk) q <= s ? 1'b1 : (r ? 1'b0 : q);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_outputs", {27'd0, s, r, conflict, set_level, rst_level}, 32'd0);
    end else begin
      chk("s_and_r", 32'(s & r), 32'd0);
      chk("conflict_excl", 32'(conflict & (s | r)), 32'd0);
      if (s | r | conflict) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {29'd0, conflict, r, s}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {29'd0, conflict, r, s}, {29'd0, e.kind});
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // reset held with both buttons high; release with only set held
    tick(5);
    rst_btn = 1'b0;
    rst_n   = 1'b1;
    push(K_S);
    tick(20);
    chk("rst_release_level", 32'(set_level), 32'd1);
    chk("q_after_set", 32'(q), 32'd1);
    set_btn = 1'b0;
    tick(12);
    chk("set_release_level", 32'(set_level), 32'd0);

    // clean press, held 20 cycles
    set_btn = 1'b1;
    push(K_S);
    tick(20);
    chk("clean_level", 32'(set_level), 32'd1);
    set_btn = 1'b0;
    tick(12);

    // bouncing reset press, then the flip-flop should clear
    rst_btn = 1'b1; tick(1);
    rst_btn = 1'b0; tick(1);
    rst_btn = 1'b1; tick(1);
    rst_btn = 1'b0; tick(1);
    rst_btn = 1'b1;
    push(K_R);
    tick(20);
    chk("bounce_level", 32'(rst_level), 32'd1);
    chk("q_after_rst", 32'(q), 32'd0);
    rst_btn = 1'b0;
    tick(12);
    chk("rst_release_lvl", 32'(rst_level), 32'd0);

    // 3-cycle glitch is one sample short of acceptance
    set_btn = 1'b1; tick(3);
    set_btn = 1'b0; tick(12);
    chk("glitch_level", 32'(set_level), 32'd0);

    // simultaneous rises
    set_btn = 1'b1;
    rst_btn = 1'b1;
    push(K_C);
    tick(20);
    chk("both_levels", {30'd0, set_level, rst_level}, 32'd3);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(12);

    // reset held, then set pressed
    rst_btn = 1'b1;
    push(K_R);
    tick(12);
    set_btn = 1'b1;
    push(K_C);
    tick(12);
    chk("q_after_conflict", 32'(q), 32'd0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(12);

    // mid-count reset: pending conflict is lost, held set re-debounces from 0
    rst_btn = 1'b1;
    push(K_R);
    tick(12);
    set_btn = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    #1 chk("midrst_levels", {27'd0, s, r, conflict, set_level, rst_level}, 32'd0);
    rst_btn = 1'b0;
    tick(3);
    rst_n = 1'b1;
    push(K_S);
    tick(20);
    chk("midrst_set_level", 32'(set_level), 32'd1);
    chk("q_after_midrst", 32'(q), 32'd1);
    set_btn = 1'b0;
    tick(12);

    chk("pending_expected", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Upstream command stage for the SR flip-flop: converts two raw, asynchronous, possibly bouncing push-button inputs (set and reset) into clean single-cycle `s`/`r` command pulses. Each input is synchronised, debounced with a stable-sample counter and edge-detected. Conflicting requests are suppressed so that `s` and `r` are never asserted together, which keeps the downstream flip-flop out of its forbidden S=R=1 state.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive differing synchronised samples required to accept a new level; legal range 1..255.
- `CNT_W`, 8: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low; all state clears immediately on assertion.
- `set_btn`  in  1  raw set request, asynchronous to `clk`, may bounce.
- `rst_btn`  in  1  raw reset request, asynchronous to `clk`, may bounce.
- `s`  out  1  registered set command pulse, exactly one cycle wide; drives flip-flop `s`.
- `r`  out  1  registered reset command pulse, exactly one cycle wide; drives flip-flop `r`.
- `conflict`  out  1  registered one-cycle flag; a request was dropped because the other button was active.
- `set_level`  out  1  debounced level of `set_btn`.
- `rst_level`  out  1  debounced level of `rst_btn`.

## Operation
- Per channel (set, reset), identical and independent up to the command stage:
  - Two-flop synchroniser; the second flop output is `sync`.
  - Debouncer holds `db` (debounced level) and `cnt`.
    - `sync == db`: `cnt <= 0`.
    - `sync != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
    - `sync != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= sync`, `cnt <= 0`.
    - A single agreeing sample restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` samples never change `db`.
  - Edge detect: `rise = db & ~db_d`, where `db_d` is `db` delayed by one cycle. Falling edges produce no command.
- Command stage (registered), evaluated each cycle from the current `db` values:
  - `s <= set_rise & ~rst_db`
  - `r <= rst_rise & ~set_db`
  - `conflict <= (set_rise & rst_db) | (rst_rise & set_db)`
  - Simultaneous rises on both channels: `s=0`, `r=0`, `conflict=1`.
- Invariant: `s & r` is never 1. `conflict` is never 1 in a cycle where `s` or `r` is 1.
- `set_level` is `set_db`; `rst_level` is `rst_db`.
- Holding a button produces exactly one pulse. A new pulse requires a debounced release followed by a debounced re-press.

## Timing
- Reset values: `s=0`, `r=0`, `conflict=0`, `set_level=0`, `rst_level=0`. All synchroniser flops, `db`, `db_d` and `cnt` are also 0.
- Latency: the input changes before rising edge 1 and then stays stable.
  - `sync` reflects the new level after edge 2.
  - `db` updates at edge `2+DEBOUNCE_CYCLES`.
  - `s`/`r` is high for the cycle following edge `3+DEBOUNCE_CYCLES`. With the default of 4, that is after edge 7.
- Release latency to `set_level`/`rst_level` falling is `2+DEBOUNCE_CYCLES` edges. There is no output pulse on release.
- `DEBOUNCE_CYCLES=1`: `db` follows `sync` with one cycle of delay; there is no filtering.
- Reset asserted mid-count or mid-pulse: outputs drop to 0 asynchronously and any pending pulse is lost.
- After reset release, a button still held is re-debounced from `db=0` and yields one fresh pulse at the nominal latency.
- Reset deassertion is assumed synchronous to `clk` externally. No outputs toggle during reset.

## Test plan
- Reset: drive `rst_n=0` with both buttons high -> all outputs 0 throughout; release with `set_btn` held -> `s` pulses once, after edge 7 following release (`DEBOUNCE_CYCLES=4`).
- Clean press: `set_btn` 0->1 held for 20 cycles -> exactly one `s` pulse, 1 cycle wide, after edge 7; `set_level=1`; `r=0` and `conflict=0` throughout.
- Bounce: `rst_btn` toggles 1/0/1/0 with 1-cycle spacing, then stays 1 -> no `r` until 4 consecutive high samples, then exactly one `r` pulse; glitches of 1-3 cycles produce nothing.
- Conflict: both buttons rise in the same cycle -> `conflict` pulses once, `s=0`, `r=0`; alternatively, `rst_btn` held debounced and then `set_btn` pressed -> `conflict=1`, no `s`.
- Sequence to flip-flop: set press, release, reset press, release -> `s` pulse then `r` pulse; the downstream flip-flop `q` goes 1 then 0; `s & r` is 0 every cycle (assertion).
- Mid-operation reset: assert `rst_n` 2 cycles into a debounce count -> outputs 0 immediately; after release, count restarts from 0 and the pulse occurs at the full nominal latency.
